// File: rtl/redmule_tiler_seq.sv
// GEMM tiling stage: sequential divide/multiply over a latched job descriptor, valid/ready result bus.
// Define REDMULE_TILER_ZERO_CHECK_EN to reject descriptors with a zero m, n or k size.
module redmule_tiler_seq #(
  parameter int unsigned ARRAY_W   = 12,
  parameter int unsigned ARRAY_H   = 4,
  parameter int unsigned PIPE_REGS = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [15:0] m_size_i,
  input  logic [15:0] n_size_i,
  input  logic [15:0] k_size_i,
  input  logic        fmt_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] x_rows_iter_o,
  output logic [15:0] x_cols_iter_o,
  output logic [15:0] w_rows_iter_o,
  output logic [15:0] w_cols_iter_o,
  output logic [7:0]  x_rows_lftovr_o,
  output logic [7:0]  x_cols_lftovr_o,
  output logic [7:0]  w_rows_lftovr_o,
  output logic [7:0]  w_cols_lftovr_o,
  output logic [15:0] tot_stores_o,
  output logic [31:0] tot_x_read_o,
  output logic [31:0] w_tot_len_o,
  output logic [31:0] z_tot_len_o,
  output logic [31:0] x_d1_stride_o,
  output logic [31:0] w_d0_stride_o,
  output logic [31:0] x_rows_offs_o,
  output logic        out_err_o
);
  localparam int unsigned TILE     = ARRAY_H * (PIPE_REGS + 1);
  localparam int unsigned TILE_LOG = $clog2(TILE);
  localparam logic [8:0]  AW9      = 9'(ARRAY_W);
  localparam logic [31:0] AW32     = 32'(ARRAY_W);
  localparam logic [15:0] TMASK    = 16'(TILE - 1);
  localparam logic [15:0] HMASK    = 16'(ARRAY_H - 1);
`ifdef REDMULE_TILER_ZERO_CHECK_EN
  localparam logic ZERO_CHK = 1'b1;
`else
  localparam logic ZERO_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DIV = 3'd1, S_MUL1 = 3'd2, S_MUL2 = 3'd3, S_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [15:0] x_rows_iter;
    logic [15:0] x_cols_iter;
    logic [15:0] w_rows_iter;
    logic [15:0] w_cols_iter;
    logic [7:0]  x_rows_lftovr;
    logic [7:0]  x_cols_lftovr;
    logic [7:0]  w_rows_lftovr;
    logic [7:0]  w_cols_lftovr;
    logic [15:0] tot_stores;
    logic [31:0] tot_x_read;
    logic [31:0] w_tot_len;
    logic [31:0] z_tot_len;
    logic [31:0] x_d1_stride;
    logic [31:0] w_d0_stride;
    logic [31:0] x_rows_offs;
  } res_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] n_q, n_d, k_q, k_d, quo_q, quo_d;
  logic        fmt_q, fmt_d, valid_q, valid_d, err_q, err_d;
  logic [7:0]  rem_q, rem_d;
  logic [31:0] acc1_q, acc1_d;
  logic [47:0] acc2_q, acc2_d, acc3_q, acc3_d;
  res_t        res_q, res_d;

  logic        zero_s;
  logic [8:0]  trial_s;
  logic [15:0] qn_s, rn_s, qk_s, rk_s, wr_s;
  logic [15:0] x_rows_iter_s, x_cols_iter_s, w_rows_iter_s, w_cols_iter_s;
  logic [3:0]  bidx_s;
  logic [31:0] xd1_s, wd0_s;

  assign zero_s  = (m_size_i == 16'd0) | (n_size_i == 16'd0) | (k_size_i == 16'd0);
  assign trial_s = {rem_q, quo_q[15]};
  assign qn_s    = n_q >> TILE_LOG;
  assign rn_s    = n_q & TMASK;
  assign qk_s    = k_q >> TILE_LOG;
  assign rk_s    = k_q & TMASK;
  assign wr_s    = n_q & HMASK;
  // Iteration counts are valid from MUL1 on, once the divider has settled.
  assign x_rows_iter_s = quo_q + {15'd0, rem_q != 8'd0};
  assign x_cols_iter_s = qn_s + {15'd0, rn_s != 16'd0};
  assign w_cols_iter_s = qk_s + {15'd0, rk_s != 16'd0};
  assign w_rows_iter_s = (wr_s == 16'd0) ? n_q : (n_q + 16'(ARRAY_H) - wr_s);
  assign bidx_s = 4'd15 - cnt_q;
  assign xd1_s  = fmt_q ? {16'd0, n_q} : {15'd0, n_q, 1'b0};
  assign wd0_s  = fmt_q ? {16'd0, k_q} : {15'd0, k_q, 1'b0};

  // Next-state and datapath: one divider bit or one multiplier bit per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    k_d     = k_q;
    fmt_d   = fmt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    acc3_d  = acc3_q;
    valid_d = valid_q;
    err_d   = err_q;
    res_d   = res_q;
    if (clear_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid_i) begin
            n_d    = n_size_i;
            k_d    = k_size_i;
            fmt_d  = fmt_i;
            quo_d  = m_size_i;
            rem_d  = 8'd0;
            cnt_d  = 4'd0;
            acc1_d = 32'd0;
            acc2_d = 48'd0;
            acc3_d = 48'd0;
            if (ZERO_CHK && zero_s) begin
              state_d = S_DONE;
              valid_d = 1'b1;
              err_d   = 1'b1;
              res_d   = '0;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DIV: begin
          if (trial_s >= AW9) begin
            rem_d = 8'(trial_s - AW9);
            quo_d = {quo_q[14:0], 1'b1};
          end else begin
            rem_d = trial_s[7:0];
            quo_d = {quo_q[14:0], 1'b0};
          end
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == 4'd15) ? S_MUL1 : S_DIV;
        end
        S_MUL1: begin
          acc1_d  = (acc1_q << 1) + (w_cols_iter_s[bidx_s] ? {16'd0, x_rows_iter_s} : 32'd0);
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == 4'd15) ? S_MUL2 : S_MUL1;
        end
        S_MUL2: begin
          acc2_d = (acc2_q << 1) + (x_cols_iter_s[bidx_s] ? {16'd0, acc1_q} : 48'd0);
          acc3_d = (acc3_q << 1) + (w_rows_iter_s[bidx_s] ? {16'd0, acc1_q} : 48'd0);
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d             = S_DONE;
            valid_d             = 1'b1;
            res_d.x_rows_iter   = x_rows_iter_s;
            res_d.x_cols_iter   = x_cols_iter_s;
            res_d.w_rows_iter   = w_rows_iter_s;
            res_d.w_cols_iter   = w_cols_iter_s;
            res_d.x_rows_lftovr = rem_q;
            res_d.x_cols_lftovr = rn_s[7:0];
            res_d.w_rows_lftovr = wr_s[7:0];
            res_d.w_cols_lftovr = rk_s[7:0];
            res_d.tot_stores    = acc1_q[15:0];
            res_d.tot_x_read    = acc2_d[31:0];
            res_d.w_tot_len     = acc3_d[31:0];
            res_d.z_tot_len     = AW32 * {16'd0, acc1_q[15:0]};
            res_d.x_d1_stride   = xd1_s;
            res_d.w_d0_stride   = wd0_s;
            res_d.x_rows_offs   = AW32 * xd1_s;
          end else begin
            state_d = S_MUL2;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      n_q     <= 16'd0;
      k_q     <= 16'd0;
      fmt_q   <= 1'b0;
      quo_q   <= 16'd0;
      rem_q   <= 8'd0;
      acc1_q  <= 32'd0;
      acc2_q  <= 48'd0;
      acc3_q  <= 48'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      k_q     <= k_d;
      fmt_q   <= fmt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      acc3_q  <= acc3_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign cfg_ready_o     = (state_q == S_IDLE);
  assign out_valid_o     = valid_q;
  assign out_err_o       = err_q;
  assign x_rows_iter_o   = res_q.x_rows_iter;
  assign x_cols_iter_o   = res_q.x_cols_iter;
  assign w_rows_iter_o   = res_q.w_rows_iter;
  assign w_cols_iter_o   = res_q.w_cols_iter;
  assign x_rows_lftovr_o = res_q.x_rows_lftovr;
  assign x_cols_lftovr_o = res_q.x_cols_lftovr;
  assign w_rows_lftovr_o = res_q.w_rows_lftovr;
  assign w_cols_lftovr_o = res_q.w_cols_lftovr;
  assign tot_stores_o    = res_q.tot_stores;
  assign tot_x_read_o    = res_q.tot_x_read;
  assign w_tot_len_o     = res_q.w_tot_len;
  assign z_tot_len_o     = res_q.z_tot_len;
  assign x_d1_stride_o   = res_q.x_d1_stride;
  assign w_d0_stride_o   = res_q.w_d0_stride;
  assign x_rows_offs_o   = res_q.x_rows_offs;

endmodule

// File: doc/redmule_tiler_seq.md
# redmule_tiler_seq

Parametrised, handshaked successor of the RedMulE tiling stage. It accepts one GEMM job descriptor (M/N/K sizes, element format), and computes iteration counts, leftovers, strides and total lengths for arbitrary array geometry using a sequential divider and sequential multipliers. Results are held on a registered output bus under valid/ready. It sits between the control regfile and the scheduler/streamer.

## Interface
- ARRAY_W, 12, array width (rows per X tile); any value 1..255
- ARRAY_H, 4, array height; power of two
- PIPE_REGS, 3, FMA pipeline registers; TILE = ARRAY_H*(PIPE_REGS+1) must be a power of two
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous abort; returns to IDLE
- cfg_valid_i / cfg_ready_o  in/out  1  job handshake
- m_size_i, n_size_i, k_size_i  in  16 each  matrix sizes
- fmt_i  in  1  0 = 16-bit elements (2 B), 1 = 8-bit elements (1 B)
- out_valid_o / out_ready_i  out/in  1  result handshake
- x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o  out  16 each
- x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o  out  8 each
- tot_stores_o  out  16  (x_rows_iter*w_cols_iter)[15:0]
- tot_x_read_o, w_tot_len_o, z_tot_len_o  out  32 each
- x_d1_stride_o, w_d0_stride_o, x_rows_offs_o  out  32 each
- out_err_o  out  1  descriptor rejected (see Configuration)

## Operation
- FSM: IDLE, DIV, MUL1, MUL2, DONE. cfg_ready_o = (state==IDLE). Acceptance is cfg_valid_i & cfg_ready_o; inputs are latched at acceptance and later changes are ignored.
- DIV, 16 cycles: restoring divider computes qm = m/ARRAY_W and rm = m%ARRAY_W. In the same cycles, shifts and masks compute qn = n/TILE, rn = n%TILE, qk = k/TILE, rk = k%TILE, and wr = n%ARRAY_H.
- x_rows_iter = qm+(rm!=0); x_cols_iter = qn+(rn!=0); w_cols_iter = qk+(rk!=0).
- w_rows_iter = n if wr==0, otherwise n+ARRAY_H-wr. Width is 16 bits; overflow wraps modulo 2^16.
- Leftovers: x_rows = rm, x_cols = rn, w_rows = wr, w_cols = rk. Each is truncated to 8 bits.
- MUL1, 16 cycles: shift-add computes p1 = x_rows_iter*w_cols_iter (32 b).
- MUL2, 16 cycles: two shift-add units in parallel compute p2 = p1*x_cols_iter and p3 = p1*w_rows_iter (48 b each).
- Outputs:
  - tot_x_read = p2[31:0]
  - w_tot_len = p3[31:0]
  - tot_stores = p1[15:0]
  - z_tot_len = ARRAY_W*p1[15:0]
  - x_d1_stride = B*n
  - w_d0_stride = B*k
  - x_rows_offs = ARRAY_W*x_d1_stride
  - B = 2 when fmt=0, 1 when fmt=1
- All result outputs are registered and loaded on entry to DONE. They hold stable while out_valid_o & !out_ready_i.
- DONE: out_valid_o=1. On out_ready_i, go to IDLE and clear out_valid_o. Result registers keep their last value.

## Timing
- Reset: state=IDLE. All outputs are 0 except cfg_ready_o=1.
- Latency: out_valid_o rises exactly 48 cycles after the acceptance edge (16 DIV + 16 MUL1 + 16 MUL2).
- Back-to-back: cfg_ready_o rises in the cycle after the output handshake. The minimum job period is 50 cycles.
- clear_i in any state: next cycle is IDLE with out_valid_o=0 and out_err_o=0. No result is produced. Results from previous jobs keep their values.
- If clear_i coincides with cfg_valid_i, clear wins and the job is not accepted.
- If rst_i and clear_i are both asserted, reset wins.

## Configuration
- REDMULE_TILER_ZERO_CHECK_EN defined:
  - At acceptance, a descriptor with m, n or k equal to 0 goes straight to DONE on the next cycle (latency 1).
  - That result has out_err_o=1 and all result outputs 0.
  - out_err_o clears on the output handshake.
- Not defined: zero sizes go through the normal 48-cycle computation and out_err_o is tied to 0.

## Test plan
- m=24, n=32, k=64, fmt=0 -> iters x_rows 2, x_cols 2, w_cols 4, w_rows 32; all leftovers 0; tot_stores 8; tot_x_read 16; w_tot_len 256; z_tot_len 96; x_d1_stride 64; w_d0_stride 128; x_rows_offs 768; out_valid_o exactly 48 cycles after acceptance.
- m=13, n=18, k=20, fmt=1 -> x_rows 2/lftovr 1; x_cols 2/lftovr 2; w_cols 2/lftovr 4; w_rows 20/lftovr 2; tot_stores 4; tot_x_read 8; w_tot_len 80; x_d1_stride 18; w_d0_stride 20; x_rows_offs 216.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o -> outputs stable, cfg_ready_o=0, and a second cfg_valid_i is not accepted. Then release -> second job accepted next cycle.
- clear_i pulsed in MUL1 -> IDLE the next cycle, no out_valid_o ever appears for that job, and a following job completes correctly.
- n=65535 (m=12, k=16) -> w_rows lftovr 3, w_rows_iter 0 (wrap), w_tot_len 0.
- m=0: with REDMULE_TILER_ZERO_CHECK_EN -> out_valid_o and out_err_o after 1 cycle, all results 0. Without it -> out_valid_o after 48 cycles, x_rows_iter 0, tot_stores 0, out_err_o 0.
